pcie_rx_demux: RTL and testbench

- Packet-aware AXI-Stream demultiplexer between the 7-series PCIe core RX interface and NUM_PORTS consumers (hardware PIO engine, Ethernet encapsulator, spare).
- The route is decoded once per TLP from the BAR-hit bits on the first beat and held until tlast.
- One registered output stage with a 2-entry skid buffer. Each consumer has its own tready, so a stalled consumer backpressures only the PCIe core.
- Per-port packet counters and a drop counter for TLPs routed to the drop sink.

---
 rtl/pcie_rx_pkg.sv | 27 ++
 rtl/axis_skid2.sv | 39 +++
 rtl/pcie_rx_demux.sv | 106 ++++++++++
 tb/tb_pcie_rx_demux.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_rx_pkg.sv
// pcie_rx_pkg: shared beat type, tuser BAR-hit positions and BAR-to-port route helper.
package pcie_rx_pkg;
    localparam int TUSER_BAR_LSB = 2;
    localparam int TUSER_BAR_MSB = 8;
    localparam int NUM_BARS      = TUSER_BAR_MSB - TUSER_BAR_LSB + 1;
    localparam int TUSER_W       = 22;
    localparam int RX_DATA_W     = 64;
    localparam int MAX_PORT_W    = 4;

    typedef struct packed {
        logic [RX_DATA_W-1:0]   data;
        logic [RX_DATA_W/8-1:0] keep;
        logic                   last;
        logic [TUSER_W-1:0]     user;
    } rx_beat_t;

    // Lowest-numbered BAR hit wins; no hit routes to no_hit.
    function automatic logic [MAX_PORT_W-1:0] bar_to_port(
        input logic [NUM_BARS-1:0]            hit,
        input logic [NUM_BARS*MAX_PORT_W-1:0] map,
        input logic [MAX_PORT_W-1:0]          no_hit
    );
        bar_to_port = no_hit;
        for (int i = NUM_BARS - 1; i >= 0; i--)
            if (hit[i]) bar_to_port = map[i*MAX_PORT_W +: MAX_PORT_W];
    endfunction
endpackage

// File: rtl/axis_skid2.sv
// axis_skid2: generic 2-entry skid FIFO whose input ready is registered from occupancy.
module axis_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem [2];
    logic         wp, rp, push, pop;
    logic [1:0]   cnt, cnt_nxt;

    assign push      = in_valid && in_ready;
    assign out_valid = cnt != 2'd0;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rp];
    assign cnt_nxt   = cnt + 2'(push) - 2'(pop);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp       <= 1'b0;
            rp       <= 1'b0;
            cnt      <= 2'd0;
            in_ready <= 1'b0;
        end else begin
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            cnt      <= cnt_nxt;
            in_ready <= cnt_nxt != 2'd2;
        end

    always_ff @(posedge clk)
        if (push) mem[wp] <= in_data;
endmodule

// File: rtl/pcie_rx_demux.sv
// pcie_rx_demux: per-TLP BAR-hit routing of the PCIe RX stream to NUM_PORTS consumers or a drop sink.
// The datapath width follows the package beat type; C_DATA_WIDTH must match it.
module pcie_rx_demux
    import pcie_rx_pkg::*;
#(
    parameter int                  C_DATA_WIDTH = RX_DATA_W,
    parameter int                  KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int                  NUM_PORTS    = 3,
    parameter int                  PORT_W       = $clog2(NUM_PORTS + 1),
    parameter logic [7*PORT_W-1:0] BAR_PORT_MAP = '0,
    parameter int                  NO_HIT_PORT  = 1,
    parameter int                  CNT_W        = 32
) (
    input  logic                       user_clk,
    input  logic                       user_rst_n,
    input  logic                       s_axis_rx_tvalid,
    output logic                       s_axis_rx_tready,
    input  logic                       s_axis_rx_tlast,
    input  logic [KEEP_WIDTH-1:0]      s_axis_rx_tkeep,
    input  logic [C_DATA_WIDTH-1:0]    s_axis_rx_tdata,
    input  logic [21:0]                s_axis_rx_tuser,
    output logic [NUM_PORTS-1:0]       m_axis_tvalid,
    input  logic [NUM_PORTS-1:0]       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic [C_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [21:0]                m_axis_tuser,
    output logic [NUM_PORTS*CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clr_cnt
);
    localparam int PW = PORT_W + $bits(rx_beat_t);

    logic [NUM_BARS*MAX_PORT_W-1:0] map_w;
    logic                           in_pkt, accept, head_valid, head_ready, drop;
    logic [PORT_W-1:0]              route, sof_dest, in_dest, head_dest;
    logic [PW-1:0]                  head_bus;
    rx_beat_t                       in_beat, head;
    logic [CNT_W-1:0]               cnt [NUM_PORTS];

    for (genvar b = 0; b < NUM_BARS; b++) begin : g_map
        assign map_w[b*MAX_PORT_W +: MAX_PORT_W] = MAX_PORT_W'(BAR_PORT_MAP[b*PORT_W +: PORT_W]);
    end

    assign sof_dest = PORT_W'(bar_to_port(s_axis_rx_tuser[TUSER_BAR_MSB:TUSER_BAR_LSB], map_w,
                                          MAX_PORT_W'(NO_HIT_PORT)));
    assign in_dest  = in_pkt ? route : sof_dest;
    assign accept   = s_axis_rx_tvalid && s_axis_rx_tready;
    assign in_beat  = '{data: s_axis_rx_tdata, keep: s_axis_rx_tkeep,
                        last: s_axis_rx_tlast, user: s_axis_rx_tuser};

    always_ff @(posedge user_clk or negedge user_rst_n)
        if (!user_rst_n) begin
            in_pkt <= 1'b0;
            route  <= '0;
        end else if (accept) begin
            in_pkt <= !s_axis_rx_tlast;
            if (!in_pkt) route <= sof_dest;
        end

    axis_skid2 #(.W(PW)) u_skid (
        .clk       (user_clk),
        .rst_n     (user_rst_n),
        .in_valid  (s_axis_rx_tvalid),
        .in_ready  (s_axis_rx_tready),
        .in_data   ({in_dest, in_beat}),
        .out_valid (head_valid),
        .out_ready (head_ready),
        .out_data  (head_bus)
    );

    assign {head_dest, head} = head_bus;
    // Any index past the last real port is the drop sink, which always accepts.
    assign drop = head_dest >= PORT_W'(NUM_PORTS);

    always_comb begin
        m_axis_tvalid = '0;
        head_ready    = drop;
        for (int p = 0; p < NUM_PORTS; p++) begin
            m_axis_tvalid[p] = head_valid && head_dest == PORT_W'(p);
            head_ready      |= m_axis_tready[p] && head_dest == PORT_W'(p);
        end
    end

    assign m_axis_tlast = head.last;
    assign m_axis_tkeep = head.keep;
    assign m_axis_tdata = head.data;
    assign m_axis_tuser = head.user;

    always_ff @(posedge user_clk or negedge user_rst_n)
        if (!user_rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) cnt[p] <= '0;
            drop_cnt <= '0;
        end else if (clr_cnt) begin
            for (int p = 0; p < NUM_PORTS; p++) cnt[p] <= '0;
            drop_cnt <= '0;
        end else if (head_valid && head_ready && head.last) begin
            if (drop) drop_cnt <= drop_cnt + CNT_W'(1);
            for (int p = 0; p < NUM_PORTS; p++)
                if (!drop && head_dest == PORT_W'(p)) cnt[p] <= cnt[p] + CNT_W'(1);
        end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
        assign pkt_cnt[p*CNT_W +: CNT_W] = cnt[p];
    end
endmodule

// File: tb/tb_pcie_rx_demux.sv
// tb_pcie_rx_demux: directed and random TLP traffic checked against a queue-based route model.
module tb_pcie_rx_demux;
    localparam int NP = 3;
    localparam int CW = 32;
    localparam logic [13:0] MAP = {2'd0, 2'd1, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0};

    int bar_map [7] = '{0, 1, 3, 0, 2, 1, 0};

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, clr_cnt = 1'b0;
    logic [7:0]     s_tkeep = '0, m_tkeep;
    logic [63:0]    s_tdata = '0, m_tdata;
    logic [21:0]    s_tuser = '0, m_tuser;
    logic [NP-1:0]  m_tvalid, m_tready = '0;
    logic           m_tlast;
    logic [NP*CW-1:0] pkt_cnt;
    logic [CW-1:0]  drop_cnt;

    always #5 clk = ~clk;

    pcie_rx_demux #(
        .C_DATA_WIDTH (64),
        .NUM_PORTS    (NP),
        .BAR_PORT_MAP (MAP),
        .NO_HIT_PORT  (1),
        .CNT_W        (CW)
    ) dut (
        .user_clk         (clk),
        .user_rst_n       (rst_n),
        .s_axis_rx_tvalid (s_tvalid),
        .s_axis_rx_tready (s_tready),
        .s_axis_rx_tlast  (s_tlast),
        .s_axis_rx_tkeep  (s_tkeep),
        .s_axis_rx_tdata  (s_tdata),
        .s_axis_rx_tuser  (s_tuser),
        .m_axis_tvalid    (m_tvalid),
        .m_axis_tready    (m_tready),
        .m_axis_tlast     (m_tlast),
        .m_axis_tkeep     (m_tkeep),
        .m_axis_tdata     (m_tdata),
        .m_axis_tuser     (m_tuser),
        .pkt_cnt          (pkt_cnt),
        .drop_cnt         (drop_cnt),
        .clr_cnt          (clr_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [21:0] user;
        int          port;
    } exp_t;

    int   n_vec = 0, n_err = 0, cyc = 0;
    exp_t q[$];
    int   acc_q[$];
    int   exp_pkt [NP];
    int   exp_drop = 0;
    bit   m_in_pkt = 0;
    int   m_route = 0;
    logic [NP-1:0] tv_hist [0:65535];
    logic          rdy_hist [0:65535];
    logic [NP-1:0] prev_tv = '0, prev_rdy = '0;
    logic [63:0]   prev_data = '0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int spec_dest(input logic [21:0] u);
        for (int i = 0; i < 7; i++) if (u[2+i]) return bar_map[i];
        return 1;
    endfunction

    function automatic void model_reset();
        q.delete();
        m_in_pkt = 0;
        m_route  = 0;
        exp_drop = 0;
        for (int p = 0; p < NP; p++) exp_pkt[p] = 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        int   d;
        tv_hist[cyc[15:0]]  = m_tvalid;
        rdy_hist[cyc[15:0]] = s_tready;
        if (!rst_n) prev_tv = '0;
        else begin
            if (prev_tv != 0 && (prev_tv & prev_rdy) == 0) begin
                chk("hold_valid", m_tvalid, prev_tv);
                chk("hold_data", m_tdata, prev_data);
            end
            if (m_tvalid != 0) chk("onehot", $countones(m_tvalid), 1);
            for (int p = 0; p < NP; p++)
                if (m_tvalid[p] && m_tready[p]) begin
                    if (q.size() == 0) chk("underflow", 1, 0);
                    else begin
                        e = q.pop_front();
                        chk("port", p, e.port);
                        chk("data", m_tdata, e.data);
                        chk("keep", m_tkeep, e.keep);
                        chk("last", m_tlast, e.last);
                        chk("user", m_tuser, e.user);
                        if (e.last) exp_pkt[p]++;
                    end
                end
            if (s_tvalid && s_tready) begin
                d = m_in_pkt ? m_route : spec_dest(s_tuser);
                if (!m_in_pkt) m_route = d;
                m_in_pkt = !s_tlast;
                if (d == NP) begin
                    if (s_tlast) exp_drop++;
                end else q.push_back('{s_tdata, s_tkeep, s_tlast, s_tuser, d});
            end
            if (clr_cnt) begin
                exp_drop = 0;
                for (int p = 0; p < NP; p++) exp_pkt[p] = 0;
            end
            prev_tv   = m_tvalid;
            prev_rdy  = m_tready;
            prev_data = m_tdata;
        end
    end

    task automatic send(input logic last, input logic [21:0] user);
        int n = 0;
        bit took;
        s_tvalid = 1'b1;
        s_tlast  = last;
        s_tuser  = user;
        s_tdata  = {$urandom, $urandom};
        s_tkeep  = 8'($urandom);
        forever begin
            @(negedge clk);
            took = s_tready;
            if (took) acc_q.push_back(cyc);
            @(posedge clk);
            #1;
            if (took) break;
            if (++n > 200) begin
                chk("send_timeout", 1, 0);
                s_tvalid = 1'b0;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        s_tvalid = 1'b0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        idle(3);
    endtask

    task automatic chk_cnt(input string tag);
        for (int p = 0; p < NP; p++)
            chk($sformatf("%s_pkt%0d", tag, p), pkt_cnt[p*CW +: CW], exp_pkt[p]);
        chk({tag, "_drop"}, drop_cnt, exp_drop);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        bit  done;
        logic [21:0] u;
        logic [NP-1:0] acc_tv;
        model_reset();
        #12;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rdy_after_rst", s_tready, 1);

        // 3-beat BAR0 TLP, port0 ready
        m_tready = 3'b001;
        acc_q.delete();
        send(0, 22'(1 << 2)); send(0, 22'(1 << 2)); send(1, 22'(1 << 2));
        idle(4);
        c0 = acc_q[0];
        for (int i = 1; i <= 3; i++) chk("t1_tv", tv_hist[16'(c0 + i)], 3'b001);
        chk("t1_tv_end", tv_hist[16'(c0 + 4)], 3'b000);
        drain();
        chk("t1_pkt0", pkt_cnt[CW-1:0], 1);
        chk_cnt("t1");

        // BAR2 -> drop with every consumer stalled
        m_tready = 3'b000;
        acc_q.delete();
        send(0, 22'(1 << 4)); send(1, 22'(1 << 4));
        idle(4);
        c0 = acc_q[0];
        chk("t2_nostall", acc_q[1] - c0, 1);
        acc_tv = '0;
        for (int i = 0; i <= 5; i++) acc_tv |= tv_hist[16'(c0 + i)];
        chk("t2_tv", acc_tv, 0);
        chk("t2_drop", drop_cnt, 1);
        chk_cnt("t2");

        // completion to port1 while port1 stalls
        m_tready = 3'b101;
        acc_q.delete();
        fork
            begin send(0, 22'h0); send(0, 22'h0); send(0, 22'h0); send(1, 22'h0); end
            begin repeat (6) @(posedge clk); #1; m_tready[1] = 1'b1; end
        join
        c0 = acc_q[0];
        chk("t3_b2b", acc_q[1] - c0, 1);
        chk("t3_rdy_fall", rdy_hist[16'(c0 + 2)], 0);
        chk("t3_stalled", acc_q[2] >= c0 + 3, 1);
        drain();
        chk_cnt("t3");

        // mid-packet tuser change must not reroute
        m_tready = 3'b111;
        send(0, 22'(1 << 2)); send(1, 22'(1 << 6));
        drain();
        chk_cnt("t4");

        // back-to-back single-beat TLPs alternating BAR0/BAR4
        acc_q.delete();
        for (int i = 0; i < 6; i++) send(1, 22'((i % 2) ? (1 << 6) : (1 << 2)));
        idle(3);
        c0 = acc_q[0];
        for (int i = 1; i < 6; i++) chk("t5_rate", acc_q[i] - acc_q[i-1], 1);
        for (int i = 0; i < 6; i++) chk("t5_tv", tv_hist[16'(c0 + 1 + i)], (i % 2) ? 3'b100 : 3'b001);
        drain();
        chk_cnt("t5");

        // clear coinciding with a tlast pop
        send(1, 22'(1 << 2));
        clr_cnt = 1'b1;
        s_tvalid = 1'b0;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        idle(2);
        chk("clr_pkt0", pkt_cnt[CW-1:0], 0);
        chk_cnt("clr");

        // async reset with a beat held mid-packet
        m_tready = 3'b000;
        send(0, 22'(1 << 2));
        s_tvalid = 1'b0;
        @(negedge clk);
        chk("t6_pre", m_tvalid, 3'b001);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_tvalid", m_tvalid, 0);
        chk("t6_rst_tready", s_tready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_cnt("t6_rst");
        m_tready = 3'b111;
        send(1, 22'(1 << 6));
        drain();
        chk("t6_sof_pkt2", pkt_cnt[2*CW +: CW], 1);
        chk_cnt("t6");

        // random traffic with random per-port backpressure
        done = 0;
        fork
            begin
                for (int k = 0; k < 80; k++) begin
                    int len = $urandom_range(1, 4);
                    logic [6:0] bars = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom);
                    for (int b = 0; b < len; b++) begin
                        u = 22'($urandom);
                        u[8:2] = (b == 0) ? bars : 7'($urandom);
                        send(b == len - 1, u);
                        if ($urandom_range(0, 3) == 0) idle(1);
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    m_tready = 3'($urandom);
                end
            end
        join
        m_tready = 3'b111;
        drain();
        chk_cnt("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
